// File: rtl/contador_pkg.sv
// Shared definitions for the millisecond BCD stopwatch: FSM encoding and decade limit.
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    SAT   = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One decade cell of the BCD counter: counts 0..9 when enabled, carries out on 9 -> 0.
module bcd_digit
  import contador_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q,
  output logic       term,
  output logic       carry
);

  assign term  = (q == BCD_MAX);
  assign carry = en & term;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (en) begin
      q <= term ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/contador_ms_bcd.sv
// Millisecond stopwatch core: start/stop/clear FSM driving a cascade of BCD decade cells.
module contador_ms_bcd
  import contador_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter bit          WRAP       = 1'b0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    tick_ms,
  input  logic                    start_stop,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    overflow
);

  state_e state_q, state_d;

  logic [NUM_DIGITS:0]   en_chain;
  logic [NUM_DIGITS-1:0] term;
  logic                  all_max;
  logic                  count_en;
  logic                  overflow_d;

  assign all_max = &term;
  // When saturating, the tick at max must not roll the cells over.
  assign count_en    = (state_q == RUN) & tick_ms & ~clear & ~(all_max & ~WRAP);
  assign en_chain[0] = count_en;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .CLK   (CLK),
      .RST   (RST),
      .en    (en_chain[k]),
      .clr   (clear),
      .q     (digits[4*k +: 4]),
      .term  (term[k]),
      .carry (en_chain[k+1])
    );
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (start_stop) state_d = RUN;
        RUN: begin
          if (tick_ms && all_max && !WRAP) state_d = SAT;
          else if (start_stop)             state_d = PAUSE;
        end
        PAUSE: if (start_stop) state_d = RUN;
        SAT:   state_d = SAT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Carry out of the top cell is exactly the rollover event.
  assign overflow_d = WRAP ? en_chain[NUM_DIGITS] : (state_d == SAT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      running  <= (state_d == RUN);
      overflow <= overflow_d;
    end
  end

endmodule
